// File: rtl/sdram_pkg.sv
// Shared definitions for the SDRAM bus arbiter.
// Holds the SDRAM command encodings ({cs_n,ras_n,cas_n,we_n}), the arbiter
// state encoding and the value driven on ba/addr while the bus is idle.
package sdram_pkg;

  localparam logic [3:0] NOP      = 4'b0111;
  localparam logic [3:0] P_CHARGE = 4'b0010;
  localparam logic [3:0] A_REF    = 4'b0001;
  localparam logic [3:0] ACTIVE   = 4'b0011;
  localparam logic [3:0] WRITE    = 4'b0100;
  localparam logic [3:0] READ     = 4'b0101;
  localparam logic [3:0] MRS      = 4'b0000;

  // Idle ba/addr lines are driven all-ones; modules replicate this bit
  // to their own widths.
  localparam logic IDLE_BIT = 1'b1;

  typedef enum logic [2:0] {
    ST_INIT  = 3'd0,
    ST_ARBIT = 3'd1,
    ST_AREF  = 3'd2,
    ST_WRITE = 3'd3,
    ST_READ  = 3'd4
  } arb_state_t;

endpackage

// File: rtl/sdram_cmd_mux.sv
// State-indexed pin mux for the SDRAM arbiter.
// Selects the owning requester's cmd/ba/addr (and write data in ST_WRITE)
// onto the pin bus with no added latency; NOP/all-ones otherwise.
// Ports:
//   force_idle      - drives the idle pattern regardless of state (reset)
//   state           - current arbiter state
//   init_*/aref_*/wr_*/rd_* - requester command, bank, address buses
//   wr_data, wr_sdram_en    - write data and its DQ-valid
//   cmd, ba, addr, dq_out, dq_oe - pin-side outputs
module sdram_cmd_mux
  import sdram_pkg::*;
#(
  parameter int ADDR_W = 13,
  parameter int BA_W   = 2,
  parameter int DATA_W = 16
) (
  input  logic              force_idle,
  input  arb_state_t        state,
  input  logic [3:0]        init_cmd,
  input  logic [BA_W-1:0]   init_ba,
  input  logic [ADDR_W-1:0] init_addr,
  input  logic [3:0]        aref_cmd,
  input  logic [BA_W-1:0]   aref_ba,
  input  logic [ADDR_W-1:0] aref_addr,
  input  logic [3:0]        wr_cmd,
  input  logic [BA_W-1:0]   wr_ba,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_sdram_en,
  input  logic [3:0]        rd_cmd,
  input  logic [BA_W-1:0]   rd_ba,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [3:0]        cmd,
  output logic [BA_W-1:0]   ba,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] dq_out,
  output logic              dq_oe
);

  always_comb begin
    cmd    = NOP;
    ba     = {BA_W{IDLE_BIT}};
    addr   = {ADDR_W{IDLE_BIT}};
    dq_out = '0;
    dq_oe  = 1'b0;
    if (!force_idle) begin
      case (state)
        ST_INIT: begin
          cmd  = init_cmd;
          ba   = init_ba;
          addr = init_addr;
        end
        ST_AREF: begin
          cmd  = aref_cmd;
          ba   = aref_ba;
          addr = aref_addr;
        end
        ST_WRITE: begin
          cmd    = wr_cmd;
          ba     = wr_ba;
          addr   = wr_addr;
          dq_out = wr_data;
          dq_oe  = wr_sdram_en;
        end
        ST_READ: begin
          cmd  = rd_cmd;
          ba   = rd_ba;
          addr = rd_addr;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/sdram_arbiter.sv
// SDRAM bus arbiter: shares the single SDRAM command/address/data bus
// between the init, auto-refresh, write and read sequencers.
// Grants one requester at a time (refresh > write > read) with a 1-cycle
// *_en pulse on the first cycle of ownership, and returns to arbitration
// on that requester's *_end pulse.
// Build option: define SDRAM_ARB_RR_EN to make the write/read tie-break
// round-robin instead of fixed write-over-read.
// Ports:
//   sys_clk, sys_rst (async, active-low)
//   init_*  : init sequencer bus and init_end level
//   aref_*  : refresh request/bus/end, aref_en grant
//   wr_*    : write request/bus/data/end, wr_en grant
//   rd_*    : read request/bus/end, rd_en grant
//   sdram_* : SDRAM pins (cke, command, ba, addr, dq_out/dq_oe)
module sdram_arbiter
  import sdram_pkg::*;
#(
  parameter int ADDR_W = 13,
  parameter int BA_W   = 2,
  parameter int DATA_W = 16
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic [3:0]        init_cmd,
  input  logic [BA_W-1:0]   init_ba,
  input  logic [ADDR_W-1:0] init_addr,
  input  logic              init_end,
  input  logic              aref_req,
  input  logic [3:0]        aref_cmd,
  input  logic [BA_W-1:0]   aref_ba,
  input  logic [ADDR_W-1:0] aref_addr,
  input  logic              aref_end,
  output logic              aref_en,
  input  logic              wr_req,
  input  logic [3:0]        wr_cmd,
  input  logic [BA_W-1:0]   wr_ba,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_sdram_en,
  input  logic              wr_end,
  output logic              wr_en,
  input  logic              rd_req,
  input  logic [3:0]        rd_cmd,
  input  logic [BA_W-1:0]   rd_ba,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_end,
  output logic              rd_en,
  output logic              sdram_cke,
  output logic              sdram_cs_n,
  output logic              sdram_ras_n,
  output logic              sdram_cas_n,
  output logic              sdram_we_n,
  output logic [BA_W-1:0]   sdram_ba,
  output logic [ADDR_W-1:0] sdram_addr,
  output logic [DATA_W-1:0] sdram_dq_out,
  output logic              sdram_dq_oe
);

  arb_state_t state, state_nxt;
  logic       grant_aref, grant_wr, grant_rd;
  logic       wr_pick, rd_pick;
  logic [3:0] pin_cmd;

`ifdef SDRAM_ARB_RR_EN
  // 1 = the most recent write/read grant went to read, so write wins a tie.
  logic last_grant;

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst)      last_grant <= 1'b1;
    else if (grant_wr) last_grant <= 1'b0;
    else if (grant_rd) last_grant <= 1'b1;
  end

  assign wr_pick = wr_req && (!rd_req || last_grant);
`else
  assign wr_pick = wr_req;
`endif
  assign rd_pick = rd_req && !wr_pick;

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) state <= ST_INIT;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    grant_aref = 1'b0;
    grant_wr   = 1'b0;
    grant_rd   = 1'b0;
    // Losing init_end anywhere outside INIT restarts the power-up sequence.
    if (state != ST_INIT && !init_end) begin
      state_nxt = ST_INIT;
    end else begin
      case (state)
        ST_INIT:  if (init_end) state_nxt = ST_ARBIT;
        ST_ARBIT: begin
          if (aref_req) begin
            state_nxt  = ST_AREF;
            grant_aref = 1'b1;
          end else if (wr_pick) begin
            state_nxt  = ST_WRITE;
            grant_wr   = 1'b1;
          end else if (rd_pick) begin
            state_nxt  = ST_READ;
            grant_rd   = 1'b1;
          end
        end
        ST_AREF:  if (aref_end) state_nxt = ST_ARBIT;
        ST_WRITE: if (wr_end)   state_nxt = ST_ARBIT;
        ST_READ:  if (rd_end)   state_nxt = ST_ARBIT;
        default:  state_nxt = ST_INIT;
      endcase
    end
  end

  // Grant pulses line up with the first cycle in the granted state.
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      aref_en <= 1'b0;
      wr_en   <= 1'b0;
      rd_en   <= 1'b0;
    end else begin
      aref_en <= grant_aref;
      wr_en   <= grant_wr;
      rd_en   <= grant_rd;
    end
  end

  sdram_cmd_mux #(
    .ADDR_W(ADDR_W),
    .BA_W  (BA_W),
    .DATA_W(DATA_W)
  ) u_cmd_mux (
    .force_idle (!sys_rst),
    .state      (state),
    .init_cmd   (init_cmd),
    .init_ba    (init_ba),
    .init_addr  (init_addr),
    .aref_cmd   (aref_cmd),
    .aref_ba    (aref_ba),
    .aref_addr  (aref_addr),
    .wr_cmd     (wr_cmd),
    .wr_ba      (wr_ba),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_sdram_en(wr_sdram_en),
    .rd_cmd     (rd_cmd),
    .rd_ba      (rd_ba),
    .rd_addr    (rd_addr),
    .cmd        (pin_cmd),
    .ba         (sdram_ba),
    .addr       (sdram_addr),
    .dq_out     (sdram_dq_out),
    .dq_oe      (sdram_dq_oe)
  );

  assign {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = pin_cmd;
  assign sdram_cke = 1'b1;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Testbench for sdram_arbiter: directed bring-up/priority/reset scenarios
// followed by randomized traffic, checked by a scoreboard fed from a
// behavioural model of the bus-ownership rules.
module tb_sdram_arbiter;

  localparam int ADDR_W = 13;
  localparam int BA_W   = 2;
  localparam int DATA_W = 16;

  localparam int P_INIT = 0;
  localparam int P_IDLE = 1;
  localparam int P_AREF = 2;
  localparam int P_WR   = 3;
  localparam int P_RD   = 4;

  typedef struct packed {
    logic [3:0]        init_cmd;
    logic [BA_W-1:0]   init_ba;
    logic [ADDR_W-1:0] init_addr;
    logic              init_end;
    logic              aref_req;
    logic [3:0]        aref_cmd;
    logic [BA_W-1:0]   aref_ba;
    logic [ADDR_W-1:0] aref_addr;
    logic              aref_end;
    logic              wr_req;
    logic [3:0]        wr_cmd;
    logic [BA_W-1:0]   wr_ba;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_sdram_en;
    logic              wr_end;
    logic              rd_req;
    logic [3:0]        rd_cmd;
    logic [BA_W-1:0]   rd_ba;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_end;
  } stim_t;

  typedef struct packed {
    logic [2:0]        en;   // {aref, wr, rd}
    logic [3:0]        cmd;
    logic [BA_W-1:0]   ba;
    logic [ADDR_W-1:0] addr;
    logic              oe;
    logic [DATA_W-1:0] dq;
  } exp_t;

  logic sys_clk = 1'b0;
  logic sys_rst;
  stim_t cur;

  logic              aref_en, wr_en, rd_en, sdram_cke;
  logic              sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n;
  logic [BA_W-1:0]   sdram_ba;
  logic [ADDR_W-1:0] sdram_addr;
  logic [DATA_W-1:0] sdram_dq_out;
  logic              sdram_dq_oe;

  always #5 sys_clk = ~sys_clk;

  sdram_arbiter #(.ADDR_W(ADDR_W), .BA_W(BA_W), .DATA_W(DATA_W)) dut (
    .sys_clk     (sys_clk),
    .sys_rst     (sys_rst),
    .init_cmd    (cur.init_cmd),
    .init_ba     (cur.init_ba),
    .init_addr   (cur.init_addr),
    .init_end    (cur.init_end),
    .aref_req    (cur.aref_req),
    .aref_cmd    (cur.aref_cmd),
    .aref_ba     (cur.aref_ba),
    .aref_addr   (cur.aref_addr),
    .aref_end    (cur.aref_end),
    .aref_en     (aref_en),
    .wr_req      (cur.wr_req),
    .wr_cmd      (cur.wr_cmd),
    .wr_ba       (cur.wr_ba),
    .wr_addr     (cur.wr_addr),
    .wr_data     (cur.wr_data),
    .wr_sdram_en (cur.wr_sdram_en),
    .wr_end      (cur.wr_end),
    .wr_en       (wr_en),
    .rd_req      (cur.rd_req),
    .rd_cmd      (cur.rd_cmd),
    .rd_ba       (cur.rd_ba),
    .rd_addr     (cur.rd_addr),
    .rd_end      (cur.rd_end),
    .rd_en       (rd_en),
    .sdram_cke   (sdram_cke),
    .sdram_cs_n  (sdram_cs_n),
    .sdram_ras_n (sdram_ras_n),
    .sdram_cas_n (sdram_cas_n),
    .sdram_we_n  (sdram_we_n),
    .sdram_ba    (sdram_ba),
    .sdram_addr  (sdram_addr),
    .sdram_dq_out(sdram_dq_out),
    .sdram_dq_oe (sdram_dq_oe)
  );

  int checks   = 0;
  int failures = 0;

  exp_t exp_q[$];
  byte  grant_log[$];
  bit   log_grants = 1'b0;

  // Reference model: who owns the bus, which grant pulse is showing,
  // and which of write/read was served last.
  int         owner;
  logic [2:0] grant;
  bit         last_was_rd;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h time=%0t", name, act, req, $time);
    end
  endtask

  function automatic void model_reset();
    owner       = P_INIT;
    grant       = 3'b000;
    last_was_rd = 1'b1;
  endfunction

  // Advance the model across one clock edge using the inputs that were held
  // during the cycle that just ended.
  function automatic void model_step();
    bit prefer_wr, take_wr;
`ifdef SDRAM_ARB_RR_EN
    prefer_wr = last_was_rd;
`else
    prefer_wr = 1'b1;
`endif
    grant = 3'b000;
    if (owner != P_INIT && !cur.init_end) begin
      owner = P_INIT;
    end else if (owner == P_INIT) begin
      if (cur.init_end) owner = P_IDLE;
    end else if (owner == P_IDLE) begin
      if (cur.aref_req) begin
        owner = P_AREF;
        grant = 3'b100;
      end else if (cur.wr_req || cur.rd_req) begin
        take_wr = cur.wr_req && (!cur.rd_req || prefer_wr);
        owner       = take_wr ? P_WR : P_RD;
        grant       = take_wr ? 3'b010 : 3'b001;
        last_was_rd = !take_wr;
      end
    end else if (owner == P_AREF) begin
      if (cur.aref_end) owner = P_IDLE;
    end else if (owner == P_WR) begin
      if (cur.wr_end) owner = P_IDLE;
    end else begin
      if (cur.rd_end) owner = P_IDLE;
    end
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    e.en   = grant;
    e.cmd  = 4'b0111;
    e.ba   = '1;
    e.addr = '1;
    e.oe   = 1'b0;
    e.dq   = '0;
    if (owner == P_INIT) begin
      e.cmd = cur.init_cmd; e.ba = cur.init_ba; e.addr = cur.init_addr;
    end else if (owner == P_AREF) begin
      e.cmd = cur.aref_cmd; e.ba = cur.aref_ba; e.addr = cur.aref_addr;
    end else if (owner == P_WR) begin
      e.cmd = cur.wr_cmd; e.ba = cur.wr_ba; e.addr = cur.wr_addr;
      e.oe  = cur.wr_sdram_en; e.dq = cur.wr_data;
    end else if (owner == P_RD) begin
      e.cmd = cur.rd_cmd; e.ba = cur.rd_ba; e.addr = cur.rd_addr;
    end
    return e;
  endfunction

  // One bus cycle: clock edge, model update, new inputs, expected outputs queued.
  task automatic apply(input stim_t s);
    @(posedge sys_clk);
    model_step();
    #1;
    cur = s;
    exp_q.push_back(model_out());
  endtask

  task automatic check_idle_pins(input string tag);
    check({tag, "_en"},   {29'd0, aref_en, wr_en, rd_en}, 32'd0);
    check({tag, "_cmd"},  {28'd0, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n}, 32'h7);
    check({tag, "_ba"},   {30'd0, sdram_ba}, 32'h3);
    check({tag, "_addr"}, {19'd0, sdram_addr}, 32'h1fff);
    check({tag, "_oe"},   {31'd0, sdram_dq_oe}, 32'd0);
    check({tag, "_dq"},   {16'd0, sdram_dq_out}, 32'd0);
    check({tag, "_cke"},  {31'd0, sdram_cke}, 32'd1);
  endtask

  // Monitor: compares every presented bus cycle against the queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge sys_clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("grant",  {29'd0, aref_en, wr_en, rd_en}, {29'd0, e.en});
        check("cmd",    {28'd0, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n}, {28'd0, e.cmd});
        check("ba",     {30'd0, sdram_ba}, {30'd0, e.ba});
        check("addr",   {19'd0, sdram_addr}, {19'd0, e.addr});
        check("dq_oe",  {31'd0, sdram_dq_oe}, {31'd0, e.oe});
        check("dq_out", {16'd0, sdram_dq_out}, {16'd0, e.dq});
        check("cke",    {31'd0, sdram_cke}, 32'd1);
        if (log_grants && wr_en) grant_log.push_back("W");
        if (log_grants && rd_en) grant_log.push_back("R");
      end
    end
  end

  initial begin
    stim_t s;
    byte   exp_order [4];

    s = '0;
    s.init_cmd  = 4'b0010;
    s.init_ba   = 2'd1;
    s.init_addr = 13'h0400;
    cur = s;
    sys_rst = 1'b0;
    model_reset();
    repeat (3) @(posedge sys_clk);
    #1;
    check_idle_pins("reset");
    #1;
    sys_rst = 1'b1;

    // Power-up: INIT drives the init bus until init_end, then NOP in ARBIT.
    repeat (20) apply(s);
    s.init_end = 1'b1;
    apply(s);
    apply(s);

    // All three request together: refresh first, then write, then read.
    s.aref_req = 1'b1; s.wr_req = 1'b1; s.rd_req = 1'b1;
    s.aref_cmd = 4'b0001; s.aref_ba = 2'd2; s.aref_addr = 13'h0055;
    s.wr_cmd   = 4'b0100; s.wr_ba   = 2'd1; s.wr_addr   = 13'h0123;
    s.rd_cmd   = 4'b0101; s.rd_ba   = 2'd3; s.rd_addr   = 13'h0abc;
    apply(s);
    s.aref_req = 1'b0;
    repeat (3) apply(s);
    s.aref_end = 1'b1; apply(s);
    s.aref_end = 1'b0; apply(s);
    apply(s);
    s.wr_req = 1'b0; s.wr_sdram_en = 1'b1; s.wr_data = 16'hA5A5;
    repeat (2) apply(s);
    s.wr_sdram_en = 1'b0; apply(s);
    s.wr_end = 1'b1; apply(s);
    s.wr_end = 1'b0; apply(s);
    apply(s);

    // Read burst: refresh request and a stray wr_end must not disturb it.
    s.rd_req = 1'b0; s.aref_req = 1'b1;
    repeat (3) apply(s);
    s.wr_end = 1'b1; apply(s);
    s.wr_end = 1'b0; apply(s);
    s.rd_end = 1'b1; apply(s);
    s.rd_end = 1'b0; apply(s);
    apply(s);
    s.aref_req = 1'b0; s.aref_end = 1'b1; apply(s);
    s.aref_end = 1'b0; s.wr_req = 1'b1; apply(s);
    s.wr_req = 1'b0; s.wr_sdram_en = 1'b1; s.wr_data = 16'h5A5A;
    apply(s);

    // Asynchronous reset on the first WRITE cycle, while wr_en is high.
    @(negedge sys_clk);
    #2;
    sys_rst = 1'b0;
    #1;
    check_idle_pins("async_rst");
    model_reset();
    s.wr_sdram_en = 1'b0;
    cur = s;
    repeat (2) @(posedge sys_clk);
    #2;
    sys_rst = 1'b1;

    // Write and read both held: observe the tie-break order.
    s.wr_req = 1'b1; s.rd_req = 1'b1;
    log_grants = 1'b1;
    for (int i = 0; i < 40; i++) begin
      s.wr_end = (i % 4 == 3);
      s.rd_end = (i % 4 == 3);
      apply(s);
    end
    @(negedge sys_clk);
    log_grants = 1'b0;
`ifdef SDRAM_ARB_RR_EN
    exp_order = '{"W", "R", "W", "R"};
`else
    exp_order = '{"W", "W", "W", "W"};
`endif
    check("grant_log_len", (grant_log.size() >= 4) ? 32'd1 : 32'd0, 32'd1);
    for (int i = 0; i < 4; i++) begin
      if (i < grant_log.size())
        check($sformatf("grant_order_%0d", i), {24'd0, grant_log[i]}, {24'd0, exp_order[i]});
    end

    // Randomized traffic.
    s.wr_end = 1'b0; s.rd_end = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      s.init_cmd    = 4'($urandom);
      s.init_ba     = 2'($urandom);
      s.init_addr   = 13'($urandom);
      s.init_end    = ($urandom_range(0, 299) != 0);
      s.aref_req    = ($urandom_range(0, 5) == 0);
      s.aref_cmd    = 4'($urandom);
      s.aref_ba     = 2'($urandom);
      s.aref_addr   = 13'($urandom);
      s.aref_end    = ($urandom_range(0, 5) == 0);
      s.wr_req      = ($urandom_range(0, 2) == 0);
      s.wr_cmd      = 4'($urandom);
      s.wr_ba       = 2'($urandom);
      s.wr_addr     = 13'($urandom);
      s.wr_data     = 16'($urandom);
      s.wr_sdram_en = 1'($urandom);
      s.wr_end      = ($urandom_range(0, 5) == 0);
      s.rd_req      = ($urandom_range(0, 2) == 0);
      s.rd_cmd      = 4'($urandom);
      s.rd_ba       = 2'($urandom);
      s.rd_addr     = 13'($urandom);
      s.rd_end      = ($urandom_range(0, 5) == 0);
      apply(s);
    end

    @(negedge sys_clk);
    #1;
    check("queue_drained", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sdram_arbiter.md
Name: sdram_arbiter

Overview:
- Owns the single SDRAM command/address/data bus and shares it between four requesters: power-up init, auto-refresh, write burst and read burst.
- Sits between those sequencers and the SDRAM pins; grants one requester at a time by pulsing its enable.
- Muxes the granted requester's command, bank and address onto the pins, and drives NOP otherwise.

Parameters:
- ADDR_W, 13, SDRAM row/column address width.
- BA_W, 2, bank address width.
- DATA_W, 16, SDRAM DQ width.

Ports:
- sys_clk  in  1  100 MHz clock.
- sys_rst  in  1  asynchronous active-low reset.
- init_cmd  in  4  init sequencer command {cs_n,ras_n,cas_n,we_n}.
- init_ba  in  BA_W  init sequencer bank address.
- init_addr  in  ADDR_W  init sequencer address.
- init_end  in  1  init sequencer done; level, stays high after init completes.
- aref_req  in  1  refresh request (level, held until granted).
- aref_cmd  in  4  refresh command.
- aref_ba  in  BA_W  refresh bank address.
- aref_addr  in  ADDR_W  refresh address.
- aref_end  in  1  refresh sequence done (1-cycle pulse).
- aref_en  out  1  refresh grant pulse.
- wr_req  in  1  write request (level).
- wr_cmd  in  4  write command.
- wr_ba  in  BA_W  write bank address.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  DATA_W  write data.
- wr_sdram_en  in  1  write data valid for DQ.
- wr_end  in  1  write done (pulse).
- wr_en  out  1  write grant pulse.
- rd_req  in  1  read request (level).
- rd_cmd  in  4  read command.
- rd_ba  in  BA_W  read bank address.
- rd_addr  in  ADDR_W  read address.
- rd_end  in  1  read done (pulse).
- rd_en  out  1  read grant pulse.
- sdram_cke  out  1  clock enable, tied 1.
- sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n  out  1 each  pin command.
- sdram_ba  out  BA_W  pin bank address.
- sdram_addr  out  ADDR_W  pin address.
- sdram_dq_out  out  DATA_W  write data to top-level tristate.
- sdram_dq_oe  out  1  DQ output enable.

Behaviour:
- Reset (sys_rst low, asynchronous): state INIT; aref_en/wr_en/rd_en = 0; pins carry NOP (4'b0111), ba all-ones, addr all-ones, dq_oe 0, dq_out 0; cke 1.
- States: INIT, ARBIT, AREF, WRITE, READ (3-bit encoding in package).
- INIT: pins = init_* bus. Go to ARBIT on the cycle after init_end is sampled high.
- ARBIT: pins NOP. Fixed priority aref_req > wr_req > rd_req. On a winner, next state is AREF/WRITE/READ and the matching *_en is registered high for exactly 1 cycle (the first cycle in the new state). With no request, stay in ARBIT.
- AREF/WRITE/READ: pins = that requester's cmd/ba/addr, combinational mux with 0 added latency. Other requests are ignored. On the matching *_end, return to ARBIT next cycle.
- WRITE: sdram_dq_oe = wr_sdram_en and sdram_dq_out = wr_data. In all other states, dq_oe = 0.
- ARBIT always lasts at least 1 cycle between grants. An end pulse coincident with a new request is arbitrated in the following ARBIT cycle, never the same cycle.
- An *_end that arrives while not in its own state is ignored.
- A request deasserted before it is granted is simply not granted. No queueing.
- Command split: {cs_n,ras_n,cas_n,we_n} = cmd[3:0].
- If init_end is low in any state other than INIT, go to INIT (defensive; does not occur in normal operation).

Optional Feature:
- Macro SDRAM_ARB_RR_EN.
- When defined: write/read tie-break is round-robin. A 1-bit last_grant register, updated on every write or read grant, gives priority to the other type when both are requesting. Refresh stays highest priority.
- When not defined: fixed priority write > read; last_grant does not exist.

Decomposition:
- Package sdram_pkg:
  - command constants NOP=4'b0111, P_CHARGE=4'b0010, A_REF=4'b0001, ACTIVE=4'b0011, WRITE=4'b0100, READ=4'b0101, MRS=4'b0000;
  - arbiter state encodings;
  - default ba/addr idle values.
- One sub-module is natural: sdram_cmd_mux (combinational state-indexed mux of cmd/ba/addr/dq onto pins). The FSM and grant logic stay in sdram_arbiter.

Test Plan:
- Hold reset, then release with init_end low 20 cycles, driving init_cmd=4'b0010 → pins show 4'b0010 in INIT. Raise init_end → ARBIT one cycle later, pins NOP 4'b0111.
- After init, assert aref_req, wr_req and rd_req together → aref_en pulses 1 cycle; pins follow aref_cmd. Pulse aref_end → ARBIT 1 cycle (NOP), then wr_en pulses.
- In WRITE with wr_sdram_en=1 and wr_data=16'hA5A5 → sdram_dq_oe=1 and dq_out=16'hA5A5. With wr_sdram_en=0 → oe=0.
- In READ, raise aref_req mid-burst → no aref_en until rd_end. aref_en asserts 2 cycles after the rd_end cycle.
- Pulse wr_end while in READ → ignored, state stays READ. Assert sys_rst low mid-WRITE → pins NOP and all *_en = 0 immediately (asynchronously); state INIT.
- With SDRAM_ARB_RR_EN, hold wr_req and rd_req high and complete each burst with its end pulse → grants alternate W,R,W,R. Without the macro → W,W,W.
